// File: rtl/vga_sync_controller_if.sv
// vga_sync_controller_if
// Bundles the pixel-step qualifier and the timing outputs of the VGA
// sync controller. The master drives ENABLE; the slave (the controller)
// drives sync, blanking, coordinates and line/frame pulses.
// FRAME_COUNT exists only when VGA_FRAME_COUNT_EN is defined.

interface vga_sync_controller_if #(
   parameter int Size = 10
);
   logic            ENABLE;
   logic            HSYNC;
   logic            VSYNC;
   logic            DISPLAY_ON;
   logic [Size-1:0] PIXEL_X;
   logic [Size-1:0] PIXEL_Y;
   logic            LINE_END;
   logic            FRAME_END;
`ifdef VGA_FRAME_COUNT_EN
   logic [7:0]      FRAME_COUNT;
`endif

   modport master (
      output ENABLE,
      input  HSYNC,
      input  VSYNC,
      input  DISPLAY_ON,
      input  PIXEL_X,
      input  PIXEL_Y,
      input  LINE_END,
`ifdef VGA_FRAME_COUNT_EN
      input  FRAME_COUNT,
`endif
      input  FRAME_END
   );

   modport slave (
      input  ENABLE,
      output HSYNC,
      output VSYNC,
      output DISPLAY_ON,
      output PIXEL_X,
      output PIXEL_Y,
      output LINE_END,
`ifdef VGA_FRAME_COUNT_EN
      output FRAME_COUNT,
`endif
      output FRAME_END
   );
endinterface

// File: rtl/vga_sync_controller.sv
// vga_sync_controller
// Horizontal/vertical pixel counters plus a per-axis porch/sync phase FSM.
// Every output is registered and updated on the same edge as the counters,
// so HSYNC/VSYNC/DISPLAY_ON always describe the current PIXEL_X/PIXEL_Y.
// Optional feature macro: VGA_FRAME_COUNT_EN adds an 8-bit FRAME_COUNT.
// Porch and sync widths are assumed non-zero.

module vga_sync_controller #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit SYNC_POL = 1'b0,
   parameter int Size     = 10
) (
   input  logic                   CLK,
   input  logic                   RESET_N,
   vga_sync_controller_if.slave   vga
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // Counter values at which each phase begins
   localparam logic [Size-1:0] H_LAST       = Size'(H_TOTAL - 1);
   localparam logic [Size-1:0] H_FP_START   = Size'(H_ACTIVE);
   localparam logic [Size-1:0] H_SYNC_START = Size'(H_ACTIVE + H_FP);
   localparam logic [Size-1:0] H_BP_START   = Size'(H_ACTIVE + H_FP + H_SYNC);

   localparam logic [Size-1:0] V_LAST       = Size'(V_TOTAL - 1);
   localparam logic [Size-1:0] V_FP_START   = Size'(V_ACTIVE);
   localparam logic [Size-1:0] V_SYNC_START = Size'(V_ACTIVE + V_FP);
   localparam logic [Size-1:0] V_BP_START   = Size'(V_ACTIVE + V_FP + V_SYNC);

   localparam logic [Size-1:0] CNT_ONE      = Size'(1);

   typedef enum logic [1:0] {
      PH_ACTIVE,
      PH_FRONT_PORCH,
      PH_SYNC,
      PH_BACK_PORCH
   } phase_t;

   // Counter and phase state
   logic [Size-1:0] hc_reg, hc_next;
   logic [Size-1:0] vc_reg, vc_next;
   phase_t          h_phase_reg, h_phase_next;
   phase_t          v_phase_reg, v_phase_next;

   // Registered outputs
   logic            hsync_reg, hsync_next;
   logic            vsync_reg, vsync_next;
   logic            display_on_reg, display_on_next;
   logic            line_end_reg, line_end_next;
   logic            frame_end_reg, frame_end_next;

   // Step qualifiers
   logic            line_wrap;
   logic            frame_wrap;

   // Moves a phase forward when the upcoming count reaches the start of the
   // next phase; otherwise the phase is kept.
   function automatic phase_t advance_phase(
      input phase_t          cur,
      input logic [Size-1:0] cnt,
      input logic [Size-1:0] fp_start,
      input logic [Size-1:0] sync_start,
      input logic [Size-1:0] bp_start
   );
      phase_t nxt;
      nxt = cur;
      case (cur)
         PH_ACTIVE:      if (cnt == fp_start)   nxt = PH_FRONT_PORCH;
         PH_FRONT_PORCH: if (cnt == sync_start) nxt = PH_SYNC;
         PH_SYNC:        if (cnt == bp_start)   nxt = PH_BACK_PORCH;
         PH_BACK_PORCH:  if (cnt == '0)         nxt = PH_ACTIVE;
         default:        nxt = PH_BACK_PORCH;
      endcase
      return nxt;
   endfunction

   // Next counter values; VC only moves on the step where HC wraps
   always_comb begin
      hc_next    = hc_reg;
      vc_next    = vc_reg;
      line_wrap  = vga.ENABLE && (hc_reg == H_LAST);
      frame_wrap = line_wrap && (vc_reg == V_LAST);
      if (vga.ENABLE) begin
         if (line_wrap) begin
            hc_next = '0;
            vc_next = (vc_reg == V_LAST) ? '0 : vc_reg + CNT_ONE;
         end else begin
            hc_next = hc_reg + CNT_ONE;
         end
      end
   end

   // Phase next-state: H on every pixel step, V only on line-wrap steps,
   // both judged on the count they are about to hold
   always_comb begin
      h_phase_next = h_phase_reg;
      v_phase_next = v_phase_reg;
      if (vga.ENABLE) begin
         h_phase_next = advance_phase(h_phase_reg, hc_next,
                                      H_FP_START, H_SYNC_START, H_BP_START);
      end
      if (line_wrap) begin
         v_phase_next = advance_phase(v_phase_reg, vc_next,
                                      V_FP_START, V_SYNC_START, V_BP_START);
      end
   end

   // Output next values derived from the next phases so they line up with
   // the next coordinates; pulses follow the wrap of this step only
   always_comb begin
      hsync_next      = (h_phase_next == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
      vsync_next      = (v_phase_next == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
      display_on_next = (h_phase_next == PH_ACTIVE) &&
                        (v_phase_next == PH_ACTIVE);
      line_end_next   = line_wrap;
      frame_end_next  = frame_wrap;
   end

   // Counter and phase state registers; reset parks both axes on the last
   // back-porch position so the first step lands on pixel (0,0)
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         hc_reg      <= H_LAST;
         vc_reg      <= V_LAST;
         h_phase_reg <= PH_BACK_PORCH;
         v_phase_reg <= PH_BACK_PORCH;
      end else begin
         hc_reg      <= hc_next;
         vc_reg      <= vc_next;
         h_phase_reg <= h_phase_next;
         v_phase_reg <= v_phase_next;
      end
   end

   // Output registers; reset drops any sync pulse in progress immediately
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         hsync_reg      <= ~SYNC_POL;
         vsync_reg      <= ~SYNC_POL;
         display_on_reg <= 1'b0;
         line_end_reg   <= 1'b0;
         frame_end_reg  <= 1'b0;
      end else begin
         hsync_reg      <= hsync_next;
         vsync_reg      <= vsync_next;
         display_on_reg <= display_on_next;
         line_end_reg   <= line_end_next;
         frame_end_reg  <= frame_end_next;
      end
   end

   assign vga.HSYNC      = hsync_reg;
   assign vga.VSYNC      = vsync_reg;
   assign vga.DISPLAY_ON = display_on_reg;
   assign vga.PIXEL_X    = hc_reg;
   assign vga.PIXEL_Y    = vc_reg;
   assign vga.LINE_END   = line_end_reg;
   assign vga.FRAME_END  = frame_end_reg;

`ifdef VGA_FRAME_COUNT_EN
   logic [7:0] frame_count_reg;

   // Counts frame starts; bumps on the same edge that raises FRAME_END
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         frame_count_reg <= 8'd0;
      end else if (frame_wrap) begin
         frame_count_reg <= frame_count_reg + 8'd1;
      end
   end

   assign vga.FRAME_COUNT = frame_count_reg;
`endif

endmodule

// File: tb/tb_vga_sync_controller.sv
// tb_vga_sync_controller
// Small timing (15x9 totals) so whole frames fit in a short run.
// Reference: position after n pixel steps is pure arithmetic on n.
// Optional feature macro: VGA_FRAME_COUNT_EN enables FRAME_COUNT checks.

module tb_vga_sync_controller;

   localparam int HA = 8, HFP = 2, HS = 3, HBP = 2;
   localparam int VA = 4, VFP = 1, VS = 2, VBP = 2;
   localparam int HT = HA + HFP + HS + HBP;
   localparam int VT = VA + VFP + VS + VBP;
   localparam int FT = HT * VT;
   localparam int SZ = 8;

   logic CLK = 1'b0;
   logic RESET_N = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   vga_sync_controller_if #(.Size(SZ)) vga ();

   vga_sync_controller #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
      .SYNC_POL(1'b0), .Size(SZ)
   ) dut (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .vga     (vga)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int steps;
      int x, y, hs, vs, de, le, fe;
   } vec_t;

   vec_t tbl [14];

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, wanted %0d", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input int x, input int y,
                            input int hs, input int vs, input int de,
                            input int le, input int fe);
      check({tag, " PIXEL_X"},    int'(vga.PIXEL_X),    x);
      check({tag, " PIXEL_Y"},    int'(vga.PIXEL_Y),    y);
      check({tag, " HSYNC"},      int'(vga.HSYNC),      hs);
      check({tag, " VSYNC"},      int'(vga.VSYNC),      vs);
      check({tag, " DISPLAY_ON"}, int'(vga.DISPLAY_ON), de);
      check({tag, " LINE_END"},   int'(vga.LINE_END),   le);
      check({tag, " FRAME_END"},  int'(vga.FRAME_END),  fe);
   endtask

   // Reference: screen position after n enabled steps since reset
   task automatic model(input int n, input bit last_en,
                        output int x, output int y, output int hs,
                        output int vs, output int de, output int le,
                        output int fe);
      if (n == 0) begin
         x = HT - 1; y = VT - 1; hs = 1; vs = 1; de = 0; le = 0; fe = 0;
      end else begin
         x  = (n - 1) % HT;
         y  = ((n - 1) / HT) % VT;
         hs = (x >= HA + HFP && x < HA + HFP + HS) ? 0 : 1;
         vs = (y >= VA + VFP && y < VA + VFP + VS) ? 0 : 1;
         de = (x < HA && y < VA) ? 1 : 0;
         le = (last_en && x == 0) ? 1 : 0;
         fe = (le == 1 && y == 0) ? 1 : 0;
      end
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RESET_N = 1'b0;
      vga.ENABLE = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      RESET_N = 1'b1;
   endtask

   task automatic run_steps(input int n);
      repeat (n) begin
         @(negedge CLK);
         vga.ENABLE = 1'b1;
      end
      @(negedge CLK);
      vga.ENABLE = 1'b0;
   endtask

   // Watchdog so the run always ends
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int x, y, hs, vs, de, le, fe;
      int n;
      bit last_en;
      bit en;
      int pct;
      int pulses[$];

      vga.ENABLE = 1'b0;

      tbl = '{
         '{0,   14, 8, 1, 1, 0, 0, 0},
         '{1,    0, 0, 1, 1, 1, 1, 1},
         '{2,    1, 0, 1, 1, 1, 0, 0},
         '{8,    7, 0, 1, 1, 1, 0, 0},
         '{9,    8, 0, 1, 1, 0, 0, 0},
         '{11,  10, 0, 0, 1, 0, 0, 0},
         '{13,  12, 0, 0, 1, 0, 0, 0},
         '{14,  13, 0, 1, 1, 0, 0, 0},
         '{16,   0, 1, 1, 1, 1, 1, 0},
         '{75,  14, 4, 1, 1, 0, 0, 0},
         '{76,   0, 5, 1, 0, 0, 1, 0},
         '{105, 14, 6, 1, 0, 0, 0, 0},
         '{106,  0, 7, 1, 1, 0, 1, 0},
         '{136,  0, 0, 1, 1, 1, 1, 1}
      };

      // Fixed vectors: reset, then a given number of enabled steps
      for (int i = 0; i < 14; i++) begin
         do_reset();
         run_steps(tbl[i].steps);
         $display("[TB] vector %0d: %0d steps -> x=%0d y=%0d hs=%0d vs=%0d de=%0d le=%0d fe=%0d",
                  i, tbl[i].steps, vga.PIXEL_X, vga.PIXEL_Y, vga.HSYNC,
                  vga.VSYNC, vga.DISPLAY_ON, vga.LINE_END, vga.FRAME_END);
         check_all($sformatf("vec%0d", i), tbl[i].x, tbl[i].y, tbl[i].hs,
                   tbl[i].vs, tbl[i].de, tbl[i].le, tbl[i].fe);
      end

      // Pulses clear one cycle later even with ENABLE low
      do_reset();
      run_steps(1);
      @(negedge CLK);
      $display("[TB] pulse clear: le=%0d fe=%0d", vga.LINE_END, vga.FRAME_END);
      check("pulse_clear LINE_END",  int'(vga.LINE_END),  0);
      check("pulse_clear FRAME_END", int'(vga.FRAME_END), 0);
      check("pulse_clear PIXEL_X",   int'(vga.PIXEL_X),   0);
      check("pulse_clear DISPLAY_ON", int'(vga.DISPLAY_ON), 1);

      // Reset asserted inside both sync pulses returns outputs at once
      do_reset();
      run_steps(5 * HT + 12);
      check("midsync HSYNC", int'(vga.HSYNC), 0);
      check("midsync VSYNC", int'(vga.VSYNC), 0);
      check("midsync PIXEL_X", int'(vga.PIXEL_X), 11);
      check("midsync PIXEL_Y", int'(vga.PIXEL_Y), 5);
      #2;
      RESET_N = 1'b0;
      #1;
      $display("[TB] async reset: hs=%0d vs=%0d x=%0d y=%0d",
               vga.HSYNC, vga.VSYNC, vga.PIXEL_X, vga.PIXEL_Y);
      check_all("async_rst", HT - 1, VT - 1, 1, 1, 0, 0, 0);
      @(negedge CLK);
      RESET_N = 1'b1;
      run_steps(1);
      check_all("restart", 0, 0, 1, 1, 1, 1, 1);

      // ENABLE toggling 1/0: line period doubles, LINE_END stays one cycle
      do_reset();
      pulses.delete();
      for (int c = 0; c <= 4 * HT + 1; c++) begin
         @(negedge CLK);
         if (c > 0 && vga.LINE_END) pulses.push_back(c);
         vga.ENABLE = (c % 2 == 0);
      end
      vga.ENABLE = 1'b0;
      $display("[TB] toggle: %0d LINE_END pulses", pulses.size());
      check("toggle pulse count", pulses.size(), 3);
      if (pulses.size() == 3) begin
         check("toggle first pulse", pulses[0], 1);
         check("toggle gap1", pulses[1] - pulses[0], 2 * HT);
         check("toggle gap2", pulses[2] - pulses[1], 2 * HT);
      end

      // Random ENABLE against the arithmetic reference
      do_reset();
      n = 0;
      last_en = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge CLK);
         model(n, last_en, x, y, hs, vs, de, le, fe);
         check_all($sformatf("rand%0d", cyc), x, y, hs, vs, de, le, fe);
`ifdef VGA_FRAME_COUNT_EN
         check($sformatf("rand%0d FRAME_COUNT", cyc), int'(vga.FRAME_COUNT),
               ((n + FT - 1) / FT) % 256);
`endif
         pct = (cyc < 1000) ? 90 : (cyc < 2000) ? 50 : 100;
         en  = ($urandom_range(0, 99) < pct);
         vga.ENABLE = en;
         last_en = en;
         if (en) n++;
      end
      vga.ENABLE = 1'b0;
      $display("[TB] random: %0d steps applied", n);

`ifdef VGA_FRAME_COUNT_EN
      // FRAME_COUNT wraps after 256 frames
      do_reset();
      run_steps(256 * FT);
      $display("[TB] frames 256: FRAME_COUNT=%0d", vga.FRAME_COUNT);
      check("fc after 256", int'(vga.FRAME_COUNT), 0);
      run_steps(FT - 1);
      $display("[TB] frames 257: FRAME_COUNT=%0d", vga.FRAME_COUNT);
      check("fc after 257", int'(vga.FRAME_COUNT), 1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_sync_controller.md
# vga_sync_controller

Sequences the horizontal and vertical pixel counters of the VGA output path and derives sync, blanking and pixel-coordinate signals from them. Sits between the pixel-clock enable divider and the pixel generator: one ENABLE-qualified step per pixel, two nested counters (line within frame, pixel within line) and a porch/sync phase state machine per axis. Default parameters give 640x480 @ 60 Hz (800x525 totals).

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of HSYNC/VSYNC (0 = active-low)
- Size, 10, counter/coordinate width; H_TOTAL-1 and V_TOTAL-1 must fit

Ports:
- CLK  input  1  system clock
- RESET_N  input  1  asynchronous, active-low reset
- ENABLE  input  1  pixel-step qualifier; counters advance only on CLK edges with ENABLE=1
- HSYNC  output  1  horizontal sync, level SYNC_POL during H SYNC phase
- VSYNC  output  1  vertical sync, level SYNC_POL during V SYNC phase
- DISPLAY_ON  output  1  high when both axes are in ACTIVE phase
- PIXEL_X  output  Size  current horizontal count HC
- PIXEL_Y  output  Size  current vertical count VC
- LINE_END  output  1  one-CLK pulse after HC wraps to 0
- FRAME_END  output  1  one-CLK pulse after HC and VC both wrap to 0
- FRAME_COUNT  output  8  frames started (only with VGA_FRAME_COUNT_EN)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- HC counts 0..H_TOTAL-1 on ENABLE edges, wraps to 0. VC advances only on the ENABLE edge where HC wraps; VC wraps V_TOTAL-1 -> 0.
- Per-axis phase FSM, registered state: ACTIVE -> FRONT_PORCH -> SYNC -> BACK_PORCH -> ACTIVE. H transitions on ENABLE edges where next HC = H_ACTIVE, H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC, 0. V FSM transitions only on line-wrap edges, same rule on next VC.
- Phase registers must always agree with counters; any mismatch is a bug (verification asserts it every cycle).
- HSYNC = SYNC_POL when H phase is SYNC, else ~SYNC_POL; VSYNC likewise from V phase.
- All outputs registered; updated on the same edge as the counters, so outputs describe the new counter value (zero latency vs. PIXEL_X/PIXEL_Y).
- ENABLE=0: counters, phases, HSYNC, VSYNC, DISPLAY_ON, coordinates hold; LINE_END/FRAME_END still clear after one cycle.

## Timing
- Reset (RESET_N=0, asynchronous): HC=H_TOTAL-1, VC=V_TOTAL-1, both phases BACK_PORCH, HSYNC=VSYNC=~SYNC_POL, DISPLAY_ON=0, PIXEL_X=H_TOTAL-1, PIXEL_Y=V_TOTAL-1, LINE_END=FRAME_END=0, FRAME_COUNT=0.
- First ENABLE edge after reset release: HC=0, VC=0, DISPLAY_ON=1, LINE_END=1, FRAME_END=1 for exactly one CLK cycle.
- LINE_END/FRAME_END: high for one CLK cycle regardless of ENABLE in the following cycle; never stretched.
- Reset asserted mid-frame: all outputs return to reset values immediately, no partial sync pulse is completed.
- HSYNC width exactly H_SYNC ENABLE steps; VSYNC width exactly V_SYNC lines (V_SYNC*H_TOTAL steps), edges aligned to HC=0.

## Configuration
- VGA_FRAME_COUNT_EN defined: FRAME_COUNT port present; 8-bit counter increments on each FRAME_END edge, wraps 255 -> 0, reset to 0.
- Undefined: FRAME_COUNT port and its register are absent; all other behaviour identical.

## Test plan
- Reset then ENABLE held 1: cycle 1 shows PIXEL_X=0, PIXEL_Y=0, DISPLAY_ON=1, LINE_END=FRAME_END=1; cycle 2 both pulses 0.
- ENABLE held 1 for one line: DISPLAY_ON falls at PIXEL_X=640, HSYNC low for PIXEL_X 656..751 (96 cycles), next LINE_END 800 cycles after first.
- Full frame: VSYNC low for PIXEL_Y 490..491 (1600 cycles), FRAME_END period 420000 cycles, DISPLAY_ON count per frame 307200.
- ENABLE toggled 1/0 every cycle: timing scales exactly 2x, outputs hold on ENABLE=0 cycles, LINE_END still one cycle wide.
- RESET_N pulsed low at PIXEL_X=700, PIXEL_Y=490 (inside VSYNC): HSYNC/VSYNC go high asynchronously, restart behaves as first test.
- With VGA_FRAME_COUNT_EN: after 256 frames FRAME_COUNT reads 0 again, after 257 reads 1.
